mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 13 +
 rtl/mem_resp_array.sv | 22 ++
 rtl/mem_responder.sv | 107 ++++++++++
 tb/tb_mem_responder.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the wait-state memory responder.
package mem_resp_pkg;

  localparam int unsigned DEPTH_LOG2_DEF  = 8;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and the memory responder.
interface mem_responder_if;
  logic [31:0] Addr;
  logic [31:0] W_data;
  logic        R;
  logic        W;
  logic [31:0] R_data;
  logic        Ready;
  logic        Err;

  modport master (output Addr, W_data, R, W, input R_data, Ready, Err);
  modport slave  (input Addr, W_data, R, W, output R_data, Ready, Err);
endinterface

// File: rtl/mem_resp_array.sv
// Word storage: one synchronous write port, one synchronous read port, no reset.
module mem_resp_array #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Write commit and registered read, both on the same edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: samples a request, inserts wait states, then completes
// the access with a one-cycle Ready pulse (Err flags rejected requests).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic            CLK,
  input  logic            Rst,
  mem_responder_if.slave  bus
);

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic                  req, req_err;
  logic [DEPTH_LOG2-1:0] idx_q, acc_idx;
  logic [31:0]           wdata_q, acc_wdata;
  logic                  write_q, err_q, acc_write, acc_err;
  logic                  enter_done, mem_we, mem_re;
  logic                  rd_zero;
  logic [31:0]           arr_rdata;

  // Request decode and rejection checks on the live bus.
  always_comb begin
    req     = bus.R | bus.W;
    req_err = (bus.R & bus.W) | (bus.Addr[1:0] != 2'b00) |
              ((bus.Addr >> (DEPTH_LOG2 + 2)) != 32'h0);
  end

  // In IDLE the access may complete on the sampling edge itself (no wait
  // states), so the live bus is used there and the latched copy otherwise.
  always_comb begin
    acc_idx    = (state == IDLE) ? bus.Addr[DEPTH_LOG2+1:2] : idx_q;
    acc_wdata  = (state == IDLE) ? bus.W_data : wdata_q;
    acc_write  = (state == IDLE) ? bus.W : write_q;
    acc_err    = (state == IDLE) ? req_err : err_q;
    enter_done = !Rst && (next_state == DONE) && (state != DONE);
    mem_we     = enter_done && acc_write && !acc_err;
    mem_re     = enter_done && !acc_write && !acc_err;
  end

  // Request latch, captured at the sampling edge.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      idx_q   <= bus.Addr[DEPTH_LOG2+1:2];
      wdata_q <= bus.W_data;
      write_q <= bus.W;
      err_q   <= req_err;
    end
  end

  // State register and wait-state counter.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE:    if (req && WAIT_CYCLES != 0) cnt <= CNT_W'(WAIT_CYCLES - 1);
        WAIT:    if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT:    if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Completion outputs.
  always_comb begin
    bus.Ready = (state == DONE);
    bus.Err   = (state == DONE) && err_q;
  end

  // The array read register has no reset, so R_data is masked to zero from
  // reset until the first valid read reloads that register.
  always_ff @(posedge CLK) begin
    if (Rst)         rd_zero <= 1'b1;
    else if (mem_re) rd_zero <= 1'b0;
  end

  // Read data presentation.
  always_comb begin
    bus.R_data = rd_zero ? '0 : arr_rdata;
  end

  mem_resp_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (acc_idx),
    .wdata (acc_wdata),
    .re    (mem_re),
    .raddr (acc_idx),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array model.
module tb_mem_responder;

  localparam int unsigned WC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WC)) dut (
    .CLK (clk),
    .Rst (rst),
    .bus (bus)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .CLK (clk),
    .Rst (rst),
    .bus (bus0)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance. abort_j >= 0 pulses reset at the
  // negedge of post-sampling cycle abort_j, so reset lands on edge k+abort_j+1.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int abort_j);
    logic       err;
    logic [7:0] idx;
    logic       aborted;
    err     = (r && w) || (a[1:0] != 2'b00) || ((a >> 10) != 32'h0);
    idx     = a[9:2];
    aborted = 1'b0;
    @(negedge clk);
    bus.R = r; bus.W = w; bus.Addr = a; bus.W_data = d;
    @(posedge clk);
    for (int j = 0; j <= int'(WC); j++) begin
      @(negedge clk);
      if (aborted) begin
        check("abort_ready", {31'b0, bus.Ready}, 32'd0);
      end else if (j < int'(WC)) begin
        check("wait_ready", {31'b0, bus.Ready}, 32'd0);
        check("wait_err", {31'b0, bus.Err}, 32'd0);
      end else begin
        if (!err && w) model_mem[idx] = d;
        if (!err && r) model_rdata = model_mem[idx];
        check("done_ready", {31'b0, bus.Ready}, 32'd1);
        check("done_err", {31'b0, bus.Err}, {31'b0, err});
        check("done_rdata", bus.R_data, model_rdata);
      end
      bus.Addr   = (j == 0) ? a + 32'd4 : $urandom();
      bus.W_data = $urandom();
      if (aborted || abort_j >= 0) begin
        bus.R = 1'b0; bus.W = 1'b0;
      end else begin
        bus.R = 1'($urandom()); bus.W = 1'($urandom());
      end
      rst = (j == abort_j);
      if (j == abort_j) aborted = 1'b1;
    end
    if (aborted) begin
      model_rdata = 32'h0;
      check("abort_rdata", bus.R_data, 32'h0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned sel;
    a   = {22'b0, 8'($urandom()), 2'b00};
    sel = $urandom_range(0, 9);
    if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
    else if (sel == 1) a[$urandom_range(10, 31)] = 1'b1;
    return a;
  endfunction

  initial begin
    logic [31:0] v0;
    logic        r, w;
    int unsigned op;
    bus.R = 0; bus.W = 0; bus.Addr = '0; bus.W_data = '0;
    bus0.R = 0; bus0.W = 0; bus0.Addr = '0; bus0.W_data = '0;
    model_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_rdata", bus.R_data, 32'h0);
    check("rst_ready", {31'b0, bus.Ready}, 32'd0);
    check("rst_err", {31'b0, bus.Err}, 32'd0);
    check("rst0_rdata", bus0.R_data, 32'h0);

    // Fill every word so the model is fully known.
    for (int unsigned i = 0; i < 256; i++)
      access(1'b0, 1'b1, {22'b0, 8'(i), 2'b00}, $urandom(), -1);

    // Directed: write then read, then the three rejection kinds.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1);
    access(1'b1, 1'b0, 32'h10, 32'h0, -1);
    check("read_0x10", bus.R_data, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h12, 32'h0, -1);
    access(1'b1, 1'b1, 32'h20, 32'h11111111, -1);
    access(1'b0, 1'b1, 32'h400, 32'h22222222, -1);
    access(1'b1, 1'b0, 32'h20, 32'h0, -1);
    access(1'b1, 1'b0, 32'h0, 32'h0, -1);
    access(1'b1, 1'b0, 32'h10, 32'h0, -1);
    check("reject_kept_0x10", bus.R_data, 32'hDEADBEEF);

    // Reset during WAIT aborts the write; reset on the DONE-entry edge too.
    access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 0);
    access(1'b0, 1'b1, 32'h10, 32'h0BADF00D, int'(WC) - 1);
    access(1'b1, 1'b1, 32'h10, 32'h0, -1);
    access(1'b1, 1'b0, 32'h10, 32'h0, -1);
    check("abort_old_0x10", bus.R_data, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h14, 32'h0, int'(WC) - 1);

    // Random mix, including occasional aborts.
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 4);
      r  = (op <= 2);
      w  = (op == 0) || (op >= 3);
      access(r, w, rand_addr(), $urandom(), ($urandom_range(0, 19) == 0) ? 0 : -1);
    end
    @(negedge clk);
    bus.R = 0; bus.W = 0;

    // Zero-wait instance: write once, then hold a read continuously.
    v0 = $urandom();
    bus0.W = 1; bus0.Addr = 32'h40; bus0.W_data = v0;
    @(negedge clk);
    check("z_wr_ready", {31'b0, bus0.Ready}, 32'd1);
    check("z_wr_err", {31'b0, bus0.Err}, 32'd0);
    bus0.W = 0;
    @(negedge clk);
    check("z_idle_ready", {31'b0, bus0.Ready}, 32'd0);
    bus0.R = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("z_ready_pattern", {31'b0, bus0.Ready}, {31'b0, (i % 2 == 0)});
      check("z_err", {31'b0, bus0.Err}, 32'd0);
      if (i % 2 == 0) check("z_rdata", bus0.R_data, v0);
    end
    bus0.R = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
